q_flop: RTL and testbench

Synchronous Q-flop with an integrated local-clock phase generator, the building block of the Q-flop pipeline stages. It samples an asynchronous `data` input once per local-clock phase and holds the sample through a fixed resolution window. It then presents the resolved value on `out` and raises `ack`. Several instances share one rendezvous signal `go`, the C-element-combined `ack` of all flops in a stage, so the whole stage advances in lockstep.

---
 rtl/q_flop.sv | 146 ++++++++++++++
 tb/tb_q_flop.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/q_flop.sv
// ============================================================================
// q_flop : Q-flop with local-clock phase generator and go/phase rendezvous.
// Optional Q_FLOP_SAMPLE_COUNT_EN adds a 16-bit completed-sample counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module q_flop #(
  parameter int WIDTH          = 1,
  parameter int RESOLVE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] data,
  output logic             ack,
  output logic [WIDTH-1:0] out,
  output logic             phase
`ifdef Q_FLOP_SAMPLE_COUNT_EN
  ,
  output logic [15:0]      samples
`endif
);

  if (RESOLVE_CYCLES < 1 || RESOLVE_CYCLES > 15) begin : g_bad_resolve_cycles
    $error("q_flop: RESOLVE_CYCLES must be in 1..15");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("q_flop: WIDTH must be at least 1");
  end

  localparam logic [3:0] CNT_LAST = 4'(RESOLVE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] chain_q [RESOLVE_CYCLES];
  logic [WIDTH-1:0] chain_d [RESOLVE_CYCLES];
  logic [WIDTH-1:0] out_q, out_d;
  logic             ack_q, ack_d;
  logic             phase_q, phase_d;
  logic             done_evt;

  // chain[0] is the capture register; later stages are the resolution window
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chain_d  = chain_q;
    out_d    = out_q;
    ack_d    = ack_q;
    phase_d  = phase_q;
    done_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!go) begin
          state_d    = S_RESOLVE;
          phase_d    = 1'b1;
          cnt_d      = 4'd0;
          chain_d[0] = data;
        end
      end
      S_RESOLVE: begin
        for (int i = 1; i < RESOLVE_CYCLES; i++) begin
          chain_d[i] = chain_q[i-1];
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          out_d    = chain_q[RESOLVE_CYCLES-1];
          ack_d    = 1'b1;
          state_d  = S_DONE;
          done_evt = 1'b1;
        end
      end
      S_DONE: begin
        if (go) begin
          phase_d = 1'b0;
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 1'b0;
        ack_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      out_q   <= '0;
      ack_q   <= 1'b0;
      phase_q <= 1'b0;
      for (int i = 0; i < RESOLVE_CYCLES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
      phase_q <= phase_d;
      for (int i = 0; i < RESOLVE_CYCLES; i++) begin
        chain_q[i] <= chain_d[i];
      end
    end
  end

  assign ack   = ack_q;
  assign out   = out_q;
  assign phase = phase_q;

`ifdef Q_FLOP_SAMPLE_COUNT_EN
  logic [15:0] samples_q, samples_d;

  always_comb begin
    samples_d = samples_q;
    if (done_evt) begin
      samples_d = samples_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samples_q <= 16'd0;
    end else begin
      samples_q <= samples_d;
    end
  end

  assign samples = samples_q;
`else
  logic unused_done_evt;
  assign unused_done_evt = done_evt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_q_flop.sv
// Randomized scoreboard bench for q_flop against an event/deadline reference model.
`timescale 1ns/1ps

module tb_q_flop;
  localparam int W = 4;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ext_en = 1'b1;
  logic         go_ext = 1'b0;
  logic [W-1:0] data = '1;
  logic         go;
  logic         ack;
  logic         phase;
  logic [W-1:0] out;
`ifdef Q_FLOP_SAMPLE_COUNT_EN
  logic [15:0]  samples;
`endif

  assign go = ext_en ? go_ext : ack;

  q_flop #(.WIDTH(W), .RESOLVE_CYCLES(R)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .data  (data),
    .ack   (ack),
    .out   (out),
    .phase (phase)
`ifdef Q_FLOP_SAMPLE_COUNT_EN
    ,
    .samples(samples)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sample is taken when idle with go low, and its value is
  // due exactly R edges later; ack drops on the first done edge that sees go.
  int           edge_n = 0;
  int           due = 0;
  bit           m_phase = 1'b0;
  bit           m_ack = 1'b0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_cap = '0;
  logic [15:0]  m_samples = '0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin : model
    bit g;
    g = ext_en ? go_ext : m_ack;
    edge_n++;
    if (rst) begin
      m_phase   = 1'b0;
      m_ack     = 1'b0;
      m_out     = '0;
      m_samples = '0;
      exp_q.delete();
    end else if (!m_phase) begin
      if (!g) begin
        m_phase = 1'b1;
        m_cap   = data;
        due     = edge_n + R;
        exp_q.push_back(data);
      end
    end else if (!m_ack) begin
      if (edge_n == due) begin
        m_ack     = 1'b1;
        m_out     = m_cap;
        m_samples = m_samples + 16'd1;
      end
    end else if (g) begin
      m_phase = 1'b0;
      m_ack   = 1'b0;
    end
  end

  // Monitor: per-cycle state check plus scoreboard pop on every rising ack
  logic prev_ack = 1'b0;
  int   resolve_len = 0;

  always @(negedge clk) begin : monitor
    chk("phase", W'(phase), W'(m_phase));
    chk("ack", W'(ack), W'(m_ack));
    chk("out", out, m_out);
`ifdef Q_FLOP_SAMPLE_COUNT_EN
    chk("samples", W'(samples), W'(m_samples));
`endif
    if (ack === 1'b1 && prev_ack !== 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_pop: ack rose with out %h but no sample expected", out);
      end else begin
        chk("sb_out", out, exp_q.pop_front());
      end
    end
    prev_ack = ack;
    resolve_len = (phase === 1'b1 && ack === 1'b0) ? resolve_len + 1 : 0;
    if (resolve_len > R + 4) begin
      vectors++;
      miscompares++;
      $display("FAIL resolve_timeout: phase high without ack for %0d cycles", resolve_len);
      resolve_len = 0;
    end
  end

  logic [1:0] exp_ph_tab [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  logic [1:0] exp_ak_tab [8] = '{0, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    // Reset held 3 cycles with data=1, go=0
    rst = 1'b1; ext_en = 1'b1; go_ext = 1'b0; data = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", out, '0);
      chk("rst_ack", W'(ack), '0);
      chk("rst_phase", W'(phase), '0);
    end

    // Standalone timing: edge 0 is the last reset edge
    ext_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("sa_phase", W'(phase), W'(exp_ph_tab[k][0]));
      chk("sa_ack", W'(ack), W'(exp_ak_tab[k][0]));
      chk("sa_out", out, (k >= 2) ? '1 : '0);
    end

    // Hold: data toggles every cycle, only the capture-edge value may appear
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      data = W'($urandom);
    end

    // Rendezvous with external go
    ext_en = 1'b1; go_ext = 1'b0;
    for (int it = 0; it < 12; it++) begin
      int n;
      n = 0;
      while (!m_ack && n < 20) begin
        @(negedge clk);
        data = W'($urandom);
        n++;
      end
      if (!m_ack) begin
        vectors++;
        miscompares++;
        $display("FAIL rdv_wait: no ack within %0d cycles", n);
      end
      for (int h = 0; h < 5; h++) @(negedge clk);
      chk("rdv_hold_ack", W'(ack), W'(1'b1));
      chk("rdv_hold_phase", W'(phase), W'(1'b1));
      go_ext = 1'b1;
      @(negedge clk);
      chk("rdv_fall_ack", W'(ack), '0);
      for (int h = 0; h < int'($urandom_range(1, 4)); h++) begin
        @(negedge clk);
        data = W'($urandom);
        chk("rdv_block_phase", W'(phase), '0);
      end
      go_ext = 1'b0;
    end

    // Mid-operation reset in RESOLVE cycle 1
    ext_en = 1'b0; data = '1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_in_resolve", W'(phase), W'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_out", out, '0);
    chk("mid_ack", W'(ack), '0);
    chk("mid_phase", W'(phase), '0);
    for (int i = 0; i < 12; i++) @(negedge clk);

    // Randomized mix of go, data and occasional reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      data = W'($urandom);
      if ((i % 50) == 0) ext_en = $urandom_range(0, 1) != 0;
      go_ext = $urandom_range(0, 2) != 0;
      rst = ($urandom_range(0, 60) == 0);
    end

    // Long standalone run to exercise the sample counter when present
    rst = 1'b0; ext_en = 1'b0;
    for (int i = 0; i < 10 * (R + 2); i++) begin
      @(negedge clk);
      data = W'($urandom);
    end

    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
